cache_ass2vias: RTL and testbench
=================================

Name: cache_ass2vias

Overview:
- 2-way set-associative, write-back, write-allocate cache.
- Geometry: 5-bit byte-less address, 5-bit blocks, 4 sets.
- Sits between the board-level user circuit (switches/HEX) and a synchronous 32x5 RAM (ramlpm, 1-cycle read latency).
- Reports hit/miss per access and drives RAM write-back traffic.

Parameters:
- ADDR_W, 5, address width.
- DATA_W, 5, block/data width.
- SETS, 4, number of sets. Index = Address[1:0]; tag = Address[4:2] (3 bits).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- Address  in  5  access address; hold stable while ready=0.
- Write  in  1  0 = read, 1 = write; hold while ready=0.
- BlockIn  in  5  write data from circuit; hold while ready=0.
- M_Block_C  in  5  RAM read data, valid one cycle after C_Addr_M is presented with C_Write_M=0.
- BlockOut  out  5  read data to circuit.
- C_Write_M  out  1  RAM write enable (write-back).
- C_Block_M  out  5  write-back data to RAM.
- C_Addr_M  out  5  RAM address (write-back or fill).
- hit  out  1  result of the last completed access.
- ready  out  1  1 = accepting a new access this cycle.

Behaviour:
- Line state per way: valid, dirty, tag[2:0], data[4:0]. One LRU bit per set; LRU = way index to evict next.
- Reset (async): all valid/dirty/LRU = 0, FSM = IDLE.
- Output reset values: BlockOut=0, hit=0, C_Write_M=0, C_Block_M=0, C_Addr_M=0, ready=1.
- FSM states: IDLE, WB, FILL_REQ, FILL_WAIT.
- IDLE, every posedge: look up set Address[1:0] in both ways. A way hits when valid and tag equal.
- Read hit: BlockOut <= data, hit <= 1, LRU <= other way. Completes in 1 cycle; stay in IDLE.
- Write hit: data <= BlockIn, dirty <= 1, hit <= 1, LRU <= other way. 1 cycle. BlockOut unchanged.
- Miss handling:
  - hit <= 0, ready <= 0.
  - Victim selection: first invalid way (way0 before way1); if both valid, the LRU way.
  - Victim valid and dirty: enter WB.
  - Victim not dirty and Write=1: install immediately (see write-miss install below), return to IDLE.
  - Victim not dirty and Write=0: enter FILL_REQ.
- WB, one cycle: C_Write_M=1, C_Block_M=victim data, C_Addr_M={victim tag, index}. Next state:
  - Write=1: install the write data, back to IDLE.
  - Write=0: FILL_REQ.
- FILL_REQ: C_Write_M=0, C_Addr_M=Address; next FILL_WAIT.
- FILL_WAIT: capture M_Block_C into the victim (valid=1, dirty=0, tag=Address[4:2]), BlockOut <= M_Block_C, LRU <= other way, ready <= 1, back to IDLE.
- Write-miss install (no fill read, block = 1 word): victim data <= BlockIn, valid=1, dirty=1, tag set, LRU <= other way, ready <= 1.
- C_Write_M is 1 only in WB; it is 0 in every other state.
- Latencies:
  - Hit: 1 cycle.
  - Clean read miss: 3 cycles.
  - Dirty read miss: 4 cycles.
  - Clean write miss: 1 cycle.
  - Dirty write miss: 2 cycles.
- hit holds its value until the next access completes; for a miss it stays 0 through completion.
- Input changes while ready=0 are ignored: the Address/Write/BlockIn sampled in IDLE are registered and used for the whole miss.
- Reset asserted mid-miss: abort immediately; the pending write-back is lost.

Decomposition:
- Shared package cache_pkg holds:
  - ADDR_W/DATA_W/SETS constants;
  - line struct {valid, dirty, tag, data};
  - FSM state enum.
- One natural sub-module: cache_set_lookup, a combinational 2-way tag compare producing hit_way, hit, victim_way.

Test Plan:
- After reset, read Address=5'b00101 with RAM[5]=7 -> miss: hit=0, C_Addr_M=5 in FILL_REQ, BlockOut=7 after 3 cycles; repeat the read -> hit=1, BlockOut=7 in 1 cycle.
- Write Address=5, BlockIn=3 (line resident) -> hit=1, C_Write_M stays 0; read Address=5 -> BlockOut=3.
- Fill set 1 with Address 1 and 5, then read Address 9 -> LRU way evicted. Address 1 was touched last, so Address 5's way is the victim. Dirty victim (5, data 3) -> one cycle C_Write_M=1, C_Addr_M=5, C_Block_M=3, then fill from Address 9.
- Write miss to an empty set: Address 2, BlockIn=17 -> hit=0, no RAM write, ready back in 1 cycle; read Address 2 -> hit=1, BlockOut=17.
- Assert reset during FILL_WAIT -> all outputs at reset values immediately, ready=1; a subsequent read of the same address misses.

Source files
------------

// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the 2-way set-associative cache.
//   ADDR_W / DATA_W / SETS : geometry (5-bit word address, 5-bit block, 4 sets)
//   IDX_W / TAG_W / WAYS   : derived field widths and associativity
//   line_t                 : one cache line {valid, dirty, tag, data}
//   state_t                : miss-handling FSM states
//   addr_index / addr_tag  : split a word address into set index and tag
// ---------------------------------------------------------------------------
package cache_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 5;
    localparam int SETS   = 4;
    localparam int WAYS   = 2;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W;

    typedef struct packed {
        logic              valid;
        logic              dirty;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } line_t;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        FILL_REQ,
        FILL_WAIT
    } state_t;

    function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
        return addr[IDX_W-1:0];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:IDX_W];
    endfunction

endpackage

// File: rtl/cache_set_lookup.sv
// ---------------------------------------------------------------------------
// cache_set_lookup
// Combinational tag compare for one set of the 2-way cache.
//   way0, way1 : the two lines of the addressed set
//   tag        : tag of the access address
//   lru        : way to evict next when both ways are valid
//   hit        : one of the ways is valid and holds the tag
//   hit_way    : which way hit (meaningful only when hit = 1)
//   victim_way : way to replace on a miss (first invalid way, else LRU)
// ---------------------------------------------------------------------------
module cache_set_lookup
    import cache_pkg::*;
(
    input  line_t            way0,
    input  line_t            way1,
    input  logic [TAG_W-1:0] tag,
    input  logic             lru,
    output logic             hit,
    output logic             hit_way,
    output logic             victim_way
);

    logic match0;
    logic match1;

    always_comb begin
        // NOTE: every output gets a value before any branch, so no path can
        // leave one unassigned and infer a latch.
        victim_way = lru;
        match0     = way0.valid && (way0.tag == tag);
        match1     = way1.valid && (way1.tag == tag);
        hit        = match0 || match1;
        // A tag lives in at most one way of a set, so way1 hits only when way0 does not.
        hit_way    = match1 && !match0;
        if (!way0.valid) begin
            victim_way = 1'b0;
        end else if (!way1.valid) begin
            victim_way = 1'b1;
        end
    end

endmodule

// File: rtl/cache_ass2vias.sv
// ---------------------------------------------------------------------------
// cache_ass2vias
// 2-way set-associative, write-back, write-allocate cache between the board
// user circuit and a synchronous 32x5 RAM with one cycle of read latency.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   Address      : access address (held while ready = 0)
//   Write        : 0 = read, 1 = write
//   BlockIn      : write data from the circuit
//   M_Block_C    : RAM read data, valid one cycle after C_Addr_M is presented
//   BlockOut     : read data to the circuit
//   C_Write_M    : RAM write enable, high only during the write-back cycle
//   C_Block_M    : write-back data to RAM
//   C_Addr_M     : RAM address for write-back or fill
//   hit          : result of the last completed access
//   ready        : 1 = a new access is accepted this cycle
// ---------------------------------------------------------------------------
module cache_ass2vias
    import cache_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] Address,
    input  logic              Write,
    input  logic [DATA_W-1:0] BlockIn,
    input  logic [DATA_W-1:0] M_Block_C,
    output logic [DATA_W-1:0] BlockOut,
    output logic              C_Write_M,
    output logic [DATA_W-1:0] C_Block_M,
    output logic [ADDR_W-1:0] C_Addr_M,
    output logic              hit,
    output logic              ready
);

    line_t             lines [SETS][WAYS];
    logic [SETS-1:0]   lru;
    state_t            state;

    // Access captured on a miss; the live inputs are ignored until ready returns.
    logic [ADDR_W-1:0] req_addr;
    logic              req_write;
    logic [DATA_W-1:0] req_data;
    logic              vic_way;

    // Lookup on the live inputs, used only in IDLE.
    logic [IDX_W-1:0]  idx;
    line_t             way0;
    line_t             way1;
    logic              lk_hit;
    logic              lk_hit_way;
    logic              lk_victim;
    line_t             hit_line;
    line_t             victim_line;
    logic [IDX_W-1:0]  req_idx;

    assign idx         = addr_index(Address);
    assign way0        = lines[idx][0];
    assign way1        = lines[idx][1];
    assign hit_line    = lines[idx][lk_hit_way];
    assign victim_line = lines[idx][lk_victim];
    assign req_idx     = addr_index(req_addr);

    cache_set_lookup u_lookup (
        .way0       (way0),
        .way1       (way1),
        .tag        (addr_tag(Address)),
        .lru        (lru[idx]),
        .hit        (lk_hit),
        .hit_way    (lk_hit_way),
        .victim_way (lk_victim)
    );

    // NOTE: all state in this block is assigned with <=, so every read of a
    // line, LRU bit or request register sees its value from before the edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            BlockOut  <= '0;
            hit       <= 1'b0;
            C_Write_M <= 1'b0;
            C_Block_M <= '0;
            C_Addr_M  <= '0;
            ready     <= 1'b1;
            lru       <= '0;
            req_addr  <= '0;
            req_write <= 1'b0;
            req_data  <= '0;
            vic_way   <= 1'b0;
            // NOTE: the line store is small flop storage, not a RAM macro, so it
            // is cleared on reset; clearing valid is what empties the cache and
            // tag/data are zeroed only to keep the state deterministic.
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    lines[s][w] <= '0;
                end
            end
        end else begin
            // Only the transition into WB raises the RAM write enable.
            C_Write_M <= 1'b0;
            case (state)
                IDLE: begin
                    if (lk_hit) begin
                        hit          <= 1'b1;
                        lru[idx]     <= ~lk_hit_way;
                        if (Write) begin
                            lines[idx][lk_hit_way].data  <= BlockIn;
                            lines[idx][lk_hit_way].dirty <= 1'b1;
                        end else begin
                            BlockOut <= hit_line.data;
                        end
                    end else begin
                        hit       <= 1'b0;
                        req_addr  <= Address;
                        req_write <= Write;
                        req_data  <= BlockIn;
                        vic_way   <= lk_victim;
                        if (victim_line.valid && victim_line.dirty) begin
                            state     <= WB;
                            ready     <= 1'b0;
                            C_Write_M <= 1'b1;
                            C_Block_M <= victim_line.data;
                            C_Addr_M  <= {victim_line.tag, idx};
                        end else if (Write) begin
                            // Single-word blocks: a write miss never needs a fill read.
                            lines[idx][lk_victim] <= '{valid: 1'b1, dirty: 1'b1,
                                                       tag: addr_tag(Address), data: BlockIn};
                            lru[idx] <= ~lk_victim;
                            ready    <= 1'b1;
                        end else begin
                            state    <= FILL_REQ;
                            ready    <= 1'b0;
                            C_Addr_M <= Address;
                        end
                    end
                end

                WB: begin
                    if (req_write) begin
                        lines[req_idx][vic_way] <= '{valid: 1'b1, dirty: 1'b1,
                                                     tag: addr_tag(req_addr), data: req_data};
                        lru[req_idx] <= ~vic_way;
                        ready        <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        C_Addr_M <= req_addr;
                        state    <= FILL_REQ;
                    end
                end

                // The RAM samples C_Addr_M at the end of this cycle.
                FILL_REQ: begin
                    state <= FILL_WAIT;
                end

                FILL_WAIT: begin
                    lines[req_idx][vic_way] <= '{valid: 1'b1, dirty: 1'b0,
                                                 tag: addr_tag(req_addr), data: M_Block_C};
                    BlockOut     <= M_Block_C;
                    lru[req_idx] <= ~vic_way;
                    ready        <= 1'b1;
                    state        <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ass2vias.sv
// ---------------------------------------------------------------------------
// tb_cache_ass2vias
// Self-checking bench for cache_ass2vias with a behavioural 32x5 synchronous
// RAM. Each access pushes its expected outcome to a scoreboard queue; the
// entry is popped and compared when the cache raises ready again.
// ---------------------------------------------------------------------------
module tb_cache_ass2vias;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] Address;
    logic       Write;
    logic [4:0] BlockIn;
    logic [4:0] M_Block_C;
    logic [4:0] BlockOut;
    logic       C_Write_M;
    logic [4:0] C_Block_M;
    logic [4:0] C_Addr_M;
    logic       hit;
    logic       ready;

    logic       ram_load;
    logic [4:0] ram [32];

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        bit         exp_hit;
        logic [4:0] exp_block;
        int         exp_cycles;
        int         exp_wbs;
        logic [4:0] wb_addr;
        logic [4:0] wb_data;
        bit         exp_fill;
        logic [4:0] fill_addr;
    } exp_t;

    exp_t sb[$];

    always #5 clock = ~clock;

    cache_ass2vias dut (
        .clock     (clock),
        .reset     (reset),
        .Address   (Address),
        .Write     (Write),
        .BlockIn   (BlockIn),
        .M_Block_C (M_Block_C),
        .BlockOut  (BlockOut),
        .C_Write_M (C_Write_M),
        .C_Block_M (C_Block_M),
        .C_Addr_M  (C_Addr_M),
        .hit       (hit),
        .ready     (ready)
    );

    // Synchronous RAM: write-first is irrelevant here since the cache never
    // reads and writes the same cycle. Contents: addr ^ 16, with a few overrides.
    always @(posedge clock) begin
        if (ram_load) begin
            for (int i = 0; i < 32; i++) begin
                ram[i] <= 5'(i) ^ 5'h10;
            end
            ram[5] <= 5'd7;
            ram[1] <= 5'd11;
            ram[9] <= 5'd20;
        end else if (C_Write_M) begin
            ram[C_Addr_M] <= C_Block_M;
        end
        M_Block_C <= ram[C_Addr_M];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one access, scramble the inputs while the cache is busy (they must
    // be ignored), and compare against the scoreboard entry on completion.
    task automatic access(input string name, input logic [4:0] addr, input logic wr,
                          input logic [4:0] din, input bit e_hit, input logic [4:0] e_block,
                          input int e_cycles, input int e_wbs, input logic [4:0] e_wb_addr,
                          input logic [4:0] e_wb_data, input bit e_fill, input logic [4:0] e_fill_addr);
        exp_t       e;
        int         cyc;
        int         wbs;
        logic [4:0] wa;
        logic [4:0] wd;
        logic [4:0] fa;
        bit         fill_seen;
        bit         done;
        e.name       = name;
        e.exp_hit    = e_hit;
        e.exp_block  = e_block;
        e.exp_cycles = e_cycles;
        e.exp_wbs    = e_wbs;
        e.wb_addr    = e_wb_addr;
        e.wb_data    = e_wb_data;
        e.exp_fill   = e_fill;
        e.fill_addr  = e_fill_addr;
        sb.push_back(e);

        Address = addr;
        Write   = wr;
        BlockIn = din;
        cyc = 0; wbs = 0; wa = '0; wd = '0; fa = '0; fill_seen = 1'b0; done = 1'b0;
        while (!done && cyc < 12) begin
            @(posedge clock);
            #1;
            cyc++;
            if (C_Write_M) begin
                wbs++;
                wa = C_Addr_M;
                wd = C_Block_M;
            end
            if (!ready && !C_Write_M && !fill_seen) begin
                fill_seen = 1'b1;
                fa        = C_Addr_M;
            end
            if (ready) begin
                done = 1'b1;
            end else begin
                Address = ~addr;
                Write   = ~wr;
                BlockIn = ~din;
            end
        end

        e = sb.pop_front();
        check({e.name, "_done"},   32'(done),      32'd1);
        check({e.name, "_hit"},    32'(hit),       32'(e.exp_hit));
        check({e.name, "_block"},  32'(BlockOut),  32'(e.exp_block));
        check({e.name, "_cycles"}, 32'(cyc),       32'(e.exp_cycles));
        check({e.name, "_wbs"},    32'(wbs),       32'(e.exp_wbs));
        check({e.name, "_fill"},   32'(fill_seen), 32'(e.exp_fill));
        if (e.exp_wbs > 0) begin
            check({e.name, "_wb_addr"}, 32'(wa), 32'(e.wb_addr));
            check({e.name, "_wb_data"}, 32'(wd), 32'(e.wb_data));
        end
        if (e.exp_fill) begin
            check({e.name, "_fill_addr"}, 32'(fa), 32'(e.fill_addr));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_blockout"}, 32'(BlockOut),  32'd0);
        check({tag, "_hit"},      32'(hit),       32'd0);
        check({tag, "_cwrite"},   32'(C_Write_M), 32'd0);
        check({tag, "_cblock"},   32'(C_Block_M), 32'd0);
        check({tag, "_caddr"},    32'(C_Addr_M),  32'd0);
        check({tag, "_ready"},    32'(ready),     32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        ram_load = 1'b1;
        Address  = '0;
        Write    = 1'b0;
        BlockIn  = '0;
        repeat (2) @(posedge clock);
        #1;
        ram_load = 1'b0;
        check_reset_outputs("reset");
        reset = 1'b0;

        //     name           addr  wr  din  hit blk cyc wbs wa  wd  fill fa
        access("rd5_miss",    5,    0,  0,   0,  7,  3,  0,  0,  0,  1,   5);
        access("rd5_hit",     5,    0,  0,   1,  7,  1,  0,  0,  0,  0,   0);
        access("wr5_hit",     5,    1,  3,   1,  7,  1,  0,  0,  0,  0,   0);
        access("rd5_new",     5,    0,  0,   1,  3,  1,  0,  0,  0,  0,   0);
        access("rd1_miss",    1,    0,  0,   0,  11, 3,  0,  0,  0,  1,   1);
        access("rd9_evict",   9,    0,  0,   0,  20, 4,  1,  5,  3,  1,   9);
        access("rd1_hit",     1,    0,  0,   1,  11, 1,  0,  0,  0,  0,   0);
        access("wr2_miss",    2,    1,  17,  0,  11, 1,  0,  0,  0,  0,   0);
        access("rd2_hit",     2,    0,  0,   1,  17, 1,  0,  0,  0,  0,   0);
        access("wr1_hit",     1,    1,  6,   1,  17, 1,  0,  0,  0,  0,   0);
        access("rd9_hit",     9,    0,  0,   1,  20, 1,  0,  0,  0,  0,   0);
        access("wr13_dirty",  13,   1,  25,  0,  20, 2,  1,  1,  6,  0,   0);
        access("rd13_hit",    13,   0,  0,   1,  25, 1,  0,  0,  0,  0,   0);
        access("rd1_refill",  1,    0,  0,   0,  6,  3,  0,  0,  0,  1,   1);

        // Abort a clean read miss of address 6 in FILL_WAIT.
        Address = 5'd6;
        Write   = 1'b0;
        BlockIn = '0;
        @(posedge clock);
        #1;
        check("abort_fill_req_ready", 32'(ready), 32'd0);
        @(posedge clock);
        #1;
        check("abort_fill_wait_addr", 32'(C_Addr_M), 32'd6);
        reset = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(posedge clock);
        #1;
        reset = 1'b0;

        access("rd6_after",   6,    0,  0,   0,  22, 3,  0,  0,  0,  1,   6);
        access("rd2_after",   2,    0,  0,   0,  18, 3,  0,  0,  0,  1,   2);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
